// File: rtl/sseg_scan_if.sv
// Display bus as seen by the decoder: scanned anode/cathode pins in, decoded digit registers out.
// master = scan driver / monitor side, slave = sseg_scan_decoder.
interface sseg_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              sseg;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    frame_done;

  modport master (
    output an, sseg,
    input  digits, digit_valid, digit_err, frame_done
  );

  modport slave (
    input  an, sseg,
    output digits, digit_valid, digit_err, frame_done
  );
endinterface

// File: rtl/sseg_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus once a pattern has been
// stable for STABLE_CYCLES synchronized cycles; outputs are registered, no backpressure.
module sseg_scan_decoder #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input logic        clk,
  input logic        rst_n,
  sseg_scan_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = NUM_DIGITS + 7;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

  logic [NUM_DIGITS-1:0]   an_m_q, an_m_d, an_s_q, an_s_d;
  logic [6:0]              sseg_m_q, sseg_m_d, sseg_s_q, sseg_s_d;
  logic [PW-1:0]           prev_q, prev_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    frame_done_q, frame_done_d;

  logic          stable, capture, glyph_ok, blank;
  logic [3:0]    glyph_val;
  logic [3:0]    n_low;
  logic [IW-1:0] slot;

  always_comb begin
    glyph_ok  = 1'b1;
    glyph_val = 4'h0;
    case (sseg_s_q)
      7'b1000000: glyph_val = 4'h0;
      7'b1111001: glyph_val = 4'h1;
      7'b0100100: glyph_val = 4'h2;
      7'b0110000: glyph_val = 4'h3;
      7'b0011001: glyph_val = 4'h4;
      7'b0010010: glyph_val = 4'h5;
      7'b0000010: glyph_val = 4'h6;
      7'b1111000: glyph_val = 4'h7;
      7'b0000000: glyph_val = 4'h8;
      7'b0010000: glyph_val = 4'h9;
      7'b0001000: glyph_val = 4'hA;
      7'b0000011: glyph_val = 4'hB;
      7'b1000110: glyph_val = 4'hC;
      7'b0100001: glyph_val = 4'hD;
      7'b0000110: glyph_val = 4'hE;
      7'b0001110: glyph_val = 4'hF;
      default:    glyph_ok  = 1'b0;
    endcase
    blank = (sseg_s_q == 7'h7F);
  end

  always_comb begin
    an_m_d   = bus.an;
    an_s_d   = an_m_q;
    sseg_m_d = bus.sseg;
    sseg_s_d = sseg_m_q;
    prev_d   = {an_s_q, sseg_s_q};
    stable   = (prev_d == prev_q);

    cnt_d = cnt_q;
    if (!stable)
      cnt_d = '0;
    else if (cnt_q < CNT_MAX)
      cnt_d = cnt_q + 1'b1;

    n_low = 4'd0;
    slot  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s_q[i]) begin
        n_low = n_low + 4'd1;
        slot  = IW'(i);
      end
    end

    // cnt saturates past CNT_CAP, so a held pattern captures exactly once
    capture = stable && (cnt_q == CNT_CAP) && (n_low == 4'd1);

    digits_d     = digits_q;
    valid_d      = valid_q;
    err_d        = err_q;
    seen_d       = seen_q;
    frame_done_d = 1'b0;
    if (capture) begin
      if (glyph_ok) begin
        digits_d[slot*4 +: 4] = glyph_val;
        valid_d[slot]         = 1'b1;
        err_d[slot]           = 1'b0;
      end else if (blank) begin
        valid_d[slot] = 1'b0;
        err_d[slot]   = 1'b0;
      end else begin
        valid_d[slot] = 1'b0;
        err_d[slot]   = 1'b1;
      end
      seen_d[slot] = 1'b1;
      if (&seen_d) begin
        frame_done_d = 1'b1;
        seen_d       = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_m_q       <= '1;
      an_s_q       <= '1;
      sseg_m_q     <= '1;
      sseg_s_q     <= '1;
      prev_q       <= '1;
      cnt_q        <= '0;
      digits_q     <= '0;
      valid_q      <= '0;
      err_q        <= '0;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      an_m_q       <= an_m_d;
      an_s_q       <= an_s_d;
      sseg_m_q     <= sseg_m_d;
      sseg_s_q     <= sseg_s_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.digit_err   = err_q;
  assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: directed table, latency/reset/scan sequences, and a random
// pattern stream checked against a hold-run reference model.
module tb_sseg_scan_decoder;
  localparam int ND = 8;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sseg_scan_if #(.NUM_DIGITS(ND)) bus ();
  sseg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass = 0;

  int          frames = 0;
  logic [31:0] pulse_dig = '0;
  logic [7:0]  pulse_val = '0;
  always @(negedge clk) begin
    if (bus.frame_done) begin
      frames++;
      pulse_dig = bus.digits;
      pulse_val = bus.digit_valid;
    end
  end

  logic [6:0] glyph [16];

  // reference model state
  logic [3:0]  m_dig [ND];
  logic [7:0]  m_val, m_err, m_seen;
  int          m_frames;
  logic [14:0] m_last;
  int          m_run;

  typedef struct {
    logic [7:0]  an;
    logic [6:0]  sseg;
    int          hold;
    logic [31:0] e_dig;
    logic [7:0]  e_val;
    logic [7:0]  e_err;
  } vec_t;
  vec_t vt [11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [6:0] s);
    bus.an   = a;
    bus.sseg = s;
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
    m_val = '0;
    m_err = '0;
    m_seen = '0;
    m_frames = 0;
    m_last = '1;
    m_run = 0;
  endtask

  task automatic do_reset();
    drive(8'hFF, 7'h7F);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [31:0] model_digits();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) r[i*4 +: 4] = m_dig[i];
    return r;
  endfunction

  // A pattern held for SC+1 pin cycles (counting merged identical holds) is captured once.
  task automatic model_step(input logic [7:0] a, input logic [6:0] s, input int n);
    int nlow, slot, code;
    if ({a, s} == m_last) m_run += n;
    else begin
      m_last = {a, s};
      m_run = n;
    end
    if (m_run >= SC + 1 && m_run - n < SC + 1) begin
      nlow = 0;
      slot = 0;
      for (int i = 0; i < ND; i++) if (!a[i]) begin nlow++; slot = i; end
      if (nlow == 1) begin
        code = -1;
        for (int v = 0; v < 16; v++) if (glyph[v] == s) code = v;
        if (code >= 0) begin
          m_dig[slot] = 4'(code);
          m_val[slot] = 1'b1;
          m_err[slot] = 1'b0;
        end else if (s == 7'h7F) begin
          m_val[slot] = 1'b0;
          m_err[slot] = 1'b0;
        end else begin
          m_val[slot] = 1'b0;
          m_err[slot] = 1'b1;
        end
        m_seen[slot] = 1'b1;
        if (m_seen == 8'hFF) begin
          m_frames++;
          m_seen = '0;
        end
      end
    end
  endtask

  task automatic scan(input logic [31:0] val);
    logic [31:0] v;
    v = val;
    for (int k = ND - 1; k >= 0; k--) begin
      drive(~(8'h01 << k), glyph[v[k*4 +: 4]]);
      tick(8);
    end
    drive(8'hFF, 7'h7F);
    tick(4);
  endtask

  initial begin
    int fb;
    logic [7:0] a, pa;
    logic [6:0] s, ps;
    int n, r, b0, b1;

    glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    vt[0]  = '{8'hFE, 7'b0100100, 10, 32'h00000002, 8'h01, 8'h00};
    vt[1]  = '{8'hF7, 7'b0010010, 3,  32'h00000002, 8'h01, 8'h00};
    vt[2]  = '{8'hF7, 7'b0111111, 8,  32'h00000002, 8'h01, 8'h08};
    vt[3]  = '{8'hF7, 7'b0011001, 8,  32'h00004002, 8'h09, 8'h00};
    vt[4]  = '{8'hFC, 7'b0000000, 20, 32'h00004002, 8'h09, 8'h00};
    vt[5]  = '{8'hFD, 7'b1111111, 5,  32'h00004002, 8'h09, 8'h00};
    vt[6]  = '{8'hFB, 7'b0000000, 4,  32'h00004002, 8'h09, 8'h00};
    vt[7]  = '{8'hFB, 7'b0000000, 5,  32'h00004802, 8'h0D, 8'h00};
    vt[8]  = '{8'hFD, 7'b0000110, 6,  32'h000048E2, 8'h0F, 8'h00};
    vt[9]  = '{8'hFD, 7'b1111111, 5,  32'h000048E2, 8'h0D, 8'h00};
    vt[10] = '{8'hFD, 7'b1010101, 5,  32'h000048E2, 8'h0D, 8'h02};

    // reset state
    drive(8'hFF, 7'h7F);
    tick(2);
    check("rst_digits", bus.digits, 32'h0);
    check("rst_valid", {24'h0, bus.digit_valid}, 32'h0);
    check("rst_err", {24'h0, bus.digit_err}, 32'h0);
    check("rst_frame", {31'h0, bus.frame_done}, 32'h0);
    rst_n = 1'b1;
    tick(2);

    // exact capture latency: pins change after edge 0, result visible after edge SC+3
    drive(8'hDF, 7'b0001000);
    tick(SC + 2);
    check("lat_pre_valid", {24'h0, bus.digit_valid}, 32'h0);
    tick(1);
    check("lat_cap_valid", {24'h0, bus.digit_valid}, 32'h20);
    check("lat_cap_digits", bus.digits, 32'h00A00000);

    // directed table
    do_reset();
    fb = frames;
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].an, vt[i].sseg);
      tick(vt[i].hold);
      drive(8'hFF, 7'h7F);
      tick(4);
      check($sformatf("vec%0d_digits", i), bus.digits, vt[i].e_dig);
      check($sformatf("vec%0d_valid", i), {24'h0, bus.digit_valid}, {24'h0, vt[i].e_val});
      check($sformatf("vec%0d_err", i), {24'h0, bus.digit_err}, {24'h0, vt[i].e_err});
    end
    check("table_no_frame", frames - fb, 0);

    // full scans: one frame pulse each, aligned with the slot 0 capture
    do_reset();
    fb = frames;
    scan(32'h1234ABCD);
    check("scan1_digits", bus.digits, 32'h1234ABCD);
    check("scan1_valid", {24'h0, bus.digit_valid}, 32'hFF);
    check("scan1_frames", frames - fb, 1);
    check("scan1_pulse_digits", pulse_dig, 32'h1234ABCD);
    check("scan1_pulse_valid", {24'h0, pulse_val}, 32'hFF);
    tick(10);
    check("scan1_no_extra", frames - fb, 1);
    scan(32'h1234ABCD);
    check("scan2_frames", frames - fb, 2);

    // reset mid-window: async clear, then a full new window
    drive(8'hFE, glyph[7]);
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_digits", bus.digits, 32'h0);
    check("arst_valid", {24'h0, bus.digit_valid}, 32'h0);
    check("arst_err", {24'h0, bus.digit_err}, 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(SC + 2);
    check("arst_pre_valid", {24'h0, bus.digit_valid}, 32'h0);
    tick(1);
    check("arst_cap_valid", {24'h0, bus.digit_valid}, 32'h01);
    check("arst_cap_digits", bus.digits, 32'h00000007);

    // random pattern stream vs reference model
    do_reset();
    fb = frames;
    pa = 8'hFF;
    ps = 7'h7F;
    for (int seg = 0; seg < 150; seg++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        a = pa;
        s = ps;
      end else begin
        if (r == 1) a = 8'hFF;
        else if (r == 2) begin
          b0 = $urandom_range(0, ND - 1);
          b1 = (b0 + $urandom_range(1, ND - 1)) % ND;
          a = ~((8'h01 << b0) | (8'h01 << b1));
        end else a = ~(8'h01 << $urandom_range(0, ND - 1));
        r = $urandom_range(0, 9);
        if (r == 0) s = 7'h7F;
        else if (r == 1) s = 7'($urandom);
        else s = glyph[$urandom_range(0, 15)];
      end
      n = $urandom_range(2, 8);
      drive(a, s);
      tick(2);
      check($sformatf("rnd%0d_digits", seg), bus.digits, model_digits());
      check($sformatf("rnd%0d_flags", seg), {16'h0, bus.digit_valid, bus.digit_err},
            {16'h0, m_val, m_err});
      check($sformatf("rnd%0d_frames", seg), frames - fb, m_frames);
      tick(n - 2);
      model_step(a, s, n);
      pa = a;
      ps = s;
    end
    drive(8'hFF, 7'h7F);
    tick(4);
    check("rnd_end_digits", bus.digits, model_digits());
    check("rnd_end_flags", {16'h0, bus.digit_valid, bus.digit_err}, {16'h0, m_val, m_err});
    check("rnd_end_frames", frames - fb, m_frames);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
